// File: rtl/flag_register.sv
// flag_register: execute-stage condition-code register with branch resolution and interrupt flag save/restore.
// Optional FLAG_STACK_EN selects a STACK_DEPTH-entry LIFO instead of a single shadow register.
module flag_register #(
  parameter int STACK_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       stall,
  input  logic [3:0] alu_op,
  input  logic       alu_valid,
  input  logic       alu_carry,
  input  logic       alu_zero,
  input  logic       alu_neg,
  input  logic [1:0] br_type,
  input  logic       br_valid,
  input  logic       int_save,
  input  logic       rti_restore,
  output logic [2:0] flags,
  output logic       br_taken,
  output logic       stack_ovf,
  output logic       stack_unf
);
  logic [2:0] nf;
  logic [2:0] top;
  logic       upd;
  logic       sel;
  logic       full;
  logic       empty;
  logic       push;
  logic       pop;
  assign pop  = rti_restore;
  assign push = int_save & ~rti_restore;
  always_comb begin
    upd = alu_valid & (alu_op inside {4'd1, 4'd2, 4'd3, [4'd5:4'd10]});
    sel = br_type == 2'd1 ? flags[0] : br_type == 2'd2 ? flags[1] : br_type == 2'd3 ? flags[2] : 1'b0;
    br_taken = br_valid & sel;
    nf = flags & ~(br_taken ? 3'd1 << (br_type - 2'd1) : 3'd0);
    nf[1:0] = upd ? {alu_neg, alu_zero} : nf[1:0];
    nf[2] = upd ? alu_carry : (alu_valid && alu_op == 4'd11) ? 1'b1 : (alu_valid && alu_op == 4'd12) ? 1'b0 : nf[2];
  end
`ifdef FLAG_STACK_EN
  localparam int AW = STACK_DEPTH > 1 ? $clog2(STACK_DEPTH) : 1;
  localparam int PW = $clog2(STACK_DEPTH) + 1;
  logic [2:0]    stack [STACK_DEPTH];
  logic [PW-1:0] ptr;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;
  assign full   = ptr == PW'(STACK_DEPTH);
  assign empty  = ptr == '0;
  assign wr_idx = AW'(ptr);
  assign rd_idx = AW'(ptr - PW'(1));
  assign top    = stack[rd_idx];
  always_ff @(posedge clk) begin
    if (rst) ptr <= '0;
    else if (!stall) begin
      if (pop && !empty) ptr <= ptr - PW'(1);
      else if (push && !full) ptr <= ptr + PW'(1);
    end
  end
  always_ff @(posedge clk)
    if (!rst && !stall && push && !full) stack[wr_idx] <= nf;
`else
  logic [2:0] shadow;
  logic       valid;
  assign full  = valid;
  assign empty = ~valid;
  assign top   = shadow;
  always_ff @(posedge clk) begin
    if (rst) valid <= 1'b0;
    else if (!stall) begin
      if (pop && valid) valid <= 1'b0;
      else if (push && !valid) valid <= 1'b1;
    end
  end
  always_ff @(posedge clk)
    if (!rst && !stall && push && !valid) shadow <= nf;
`endif
  // A restore discards same-cycle ALU/branch updates; a failed restore leaves flags alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      flags     <= 3'b000;
      stack_ovf <= 1'b0;
      stack_unf <= 1'b0;
    end else if (!stall) begin
      if (pop) begin
        if (empty) stack_unf <= 1'b1;
        else flags <= top;
      end else flags <= nf;
      if (push && full) stack_ovf <= 1'b1;
    end
  end
endmodule

// File: tb/tb_flag_register.sv
// tb_flag_register: table-driven directed check of flag_register (default shadow build or FLAG_STACK_EN stack build).
module tb_flag_register;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       stall = 1'b0;
  logic [3:0] alu_op = 4'd0;
  logic       alu_valid = 1'b0;
  logic       alu_carry = 1'b0;
  logic       alu_zero = 1'b0;
  logic       alu_neg = 1'b0;
  logic [1:0] br_type = 2'd0;
  logic       br_valid = 1'b0;
  logic       int_save = 1'b0;
  logic       rti_restore = 1'b0;
  logic [2:0] flags;
  logic       br_taken;
  logic       stack_ovf;
  logic       stack_unf;
  int checks = 0;
  int errors = 0;
  int vn = 0;
  flag_register #(.STACK_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .stall(stall), .alu_op(alu_op), .alu_valid(alu_valid),
    .alu_carry(alu_carry), .alu_zero(alu_zero), .alu_neg(alu_neg),
    .br_type(br_type), .br_valid(br_valid), .int_save(int_save), .rti_restore(rti_restore),
    .flags(flags), .br_taken(br_taken), .stack_ovf(stack_ovf), .stack_unf(stack_unf)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic       st;
    logic [3:0] op;
    logic       av, c, n, z;
    logic [1:0] bt;
    logic       bv, sv, rt;
    logic [2:0] ef;
    logic       eb, eo, eu;
  } vec_t;
  vec_t q[$];
  function automatic vec_t mk(input logic st, input logic [3:0] op, input logic av,
                              input logic c, input logic n, input logic z,
                              input logic [1:0] bt, input logic bv, input logic sv, input logic rt,
                              input logic [2:0] ef, input logic eb, input logic eo, input logic eu);
    vec_t v;
    v.st = st; v.op = op; v.av = av; v.c = c; v.n = n; v.z = z;
    v.bt = bt; v.bv = bv; v.sv = sv; v.rt = rt;
    v.ef = ef; v.eb = eb; v.eo = eo; v.eu = eu;
    return v;
  endfunction
  task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask
  task automatic idle();
    stall = 0; alu_op = 0; alu_valid = 0; alu_carry = 0; alu_zero = 0; alu_neg = 0;
    br_type = 0; br_valid = 0; int_save = 0; rti_restore = 0;
  endtask
  task automatic run(input vec_t v);
    stall = v.st; alu_op = v.op; alu_valid = v.av; alu_carry = v.c; alu_neg = v.n; alu_zero = v.z;
    br_type = v.bt; br_valid = v.bv; int_save = v.sv; rti_restore = v.rt;
    #1;
    chk($sformatf("v%0d br_taken", vn), {2'b0, br_taken}, {2'b0, v.eb});
    @(posedge clk);
    #1;
    chk($sformatf("v%0d flags", vn), flags, v.ef);
    chk($sformatf("v%0d stack_ovf", vn), {2'b0, stack_ovf}, {2'b0, v.eo});
    chk($sformatf("v%0d stack_unf", vn), {2'b0, stack_unf}, {2'b0, v.eu});
    vn++;
  endtask
  task automatic do_reset();
    idle();
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    br_type = 2'd1; br_valid = 1;
    #1;
    chk("reset br_taken", {2'b0, br_taken}, 3'b000);
    chk("reset flags", flags, 3'b000);
    chk("reset stack_ovf", {2'b0, stack_ovf}, 3'b000);
    chk("reset stack_unf", {2'b0, stack_unf}, 3'b000);
    idle();
  endtask
  initial begin
    // st op av  c n z  bt bv sv rt  flags  br ovf unf
    q.push_back(mk(0, 6, 1, 1, 0, 1, 0, 0, 0, 0, 3'b101, 0, 0, 0));
    q.push_back(mk(0, 4, 1, 0, 1, 0, 0, 0, 0, 0, 3'b101, 0, 0, 0));
    q.push_back(mk(0, 15, 1, 0, 1, 0, 0, 0, 0, 0, 3'b101, 0, 0, 0));
    q.push_back(mk(0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 3'b010, 0, 0, 0));
    q.push_back(mk(0, 11, 1, 0, 0, 1, 0, 0, 0, 0, 3'b110, 0, 0, 0));
    q.push_back(mk(0, 12, 1, 1, 0, 1, 0, 0, 0, 0, 3'b010, 0, 0, 0));
    q.push_back(mk(0, 13, 1, 1, 1, 1, 0, 0, 0, 0, 3'b010, 0, 0, 0));
    q.push_back(mk(0, 5, 0, 1, 1, 1, 0, 0, 0, 0, 3'b010, 0, 0, 0));
    q.push_back(mk(0, 10, 1, 0, 0, 1, 0, 0, 0, 0, 3'b001, 0, 0, 0));
    q.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 3'b000, 1, 0, 0));
    q.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 3'b000, 0, 0, 0));
    q.push_back(mk(0, 8, 1, 0, 0, 1, 0, 0, 0, 0, 3'b001, 0, 0, 0));
    q.push_back(mk(0, 5, 1, 0, 0, 1, 1, 1, 0, 0, 3'b001, 1, 0, 0));
    q.push_back(mk(0, 2, 1, 1, 1, 0, 0, 0, 0, 0, 3'b110, 0, 0, 0));
    q.push_back(mk(0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 3'b110, 0, 0, 0));
    q.push_back(mk(0, 0, 0, 0, 0, 0, 3, 1, 0, 0, 3'b010, 1, 0, 0));
    q.push_back(mk(0, 3, 1, 1, 1, 0, 0, 0, 0, 0, 3'b110, 0, 0, 0));
    q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 3'b110, 0, 0, 0));
    q.push_back(mk(0, 7, 1, 0, 0, 1, 0, 0, 0, 0, 3'b001, 0, 0, 0));
    q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3'b110, 0, 0, 0));
    for (int i = 0; i < 3; i++)
      q.push_back(mk(1, 5, 1, 0, 0, 1, 2, 1, 1, 0, 3'b110, 1, 0, 0));
    q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3'b110, 0, 0, 1));
    q.push_back(mk(0, 9, 1, 0, 0, 1, 0, 0, 1, 0, 3'b001, 0, 0, 1));
    q.push_back(mk(0, 9, 1, 1, 1, 0, 0, 0, 1, 1, 3'b001, 0, 0, 1));
    q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3'b001, 0, 0, 1));
    q.push_back(mk(0, 1, 1, 1, 1, 0, 0, 0, 1, 0, 3'b110, 0, 0, 1));
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    foreach (q[i]) run(q[i]);
    do_reset();
    run(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3'b000, 0, 0, 1));
    do_reset();
`ifdef FLAG_STACK_EN
    run(mk(0, 1, 1, 0, 0, 1, 0, 0, 1, 0, 3'b001, 0, 0, 0));
    run(mk(0, 1, 1, 0, 1, 0, 0, 0, 1, 0, 3'b010, 0, 0, 0));
    run(mk(0, 1, 1, 0, 1, 1, 0, 0, 1, 0, 3'b011, 0, 0, 0));
    run(mk(0, 1, 1, 1, 0, 0, 0, 0, 1, 0, 3'b100, 0, 0, 0));
    run(mk(0, 1, 1, 1, 0, 1, 0, 0, 1, 0, 3'b101, 0, 1, 0));
    run(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3'b100, 0, 1, 0));
    run(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3'b011, 0, 1, 0));
    run(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3'b010, 0, 1, 0));
    run(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3'b001, 0, 1, 0));
    run(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3'b001, 0, 1, 1));
`else
    run(mk(0, 1, 1, 0, 0, 1, 0, 0, 1, 0, 3'b001, 0, 0, 0));
    run(mk(0, 2, 1, 1, 1, 0, 0, 0, 1, 0, 3'b110, 0, 1, 0));
    run(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3'b001, 0, 1, 0));
    run(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3'b001, 0, 1, 1));
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
